// File: rtl/rfm_dbg.sv
// Debug initiator for the rfm register file: single read/write, full dump and fill.
// RFM_DBG_FILL_EN builds the fill engine; without it a fill command returns rsp_err.
module rfm_dbg #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic          dbg_active,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_da,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_din,
  output logic          rf_wen
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RSP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_WRSP = 3'd4;
`ifdef RFM_DBG_FILL_EN
  localparam logic [2:0] S_FILL = 3'd5;
`endif

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic          dump_q, dump_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] din_q, din_d;
  logic          wen_q, wen_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          rsp_err_q, rsp_err_d;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d     = state_q;
    dump_d      = dump_q;
    ra_d        = ra_q;
    rd_d        = rd_q;
    din_d       = din_q;
    wen_d       = wen_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_READ: begin
              ra_d    = cmd_addr;
              state_d = S_RD;
            end
            OP_WRITE: begin
              rd_d    = cmd_addr;
              din_d   = cmd_data;
              wen_d   = 1'b1;
              state_d = S_WR;
            end
            OP_DUMP: begin
              ra_d    = '0;
              dump_d  = 1'b1;
              state_d = S_RD;
            end
            default: begin
`ifdef RFM_DBG_FILL_EN
              rd_d    = '0;
              din_d   = cmd_data;
              wen_d   = 1'b1;
              state_d = S_FILL;
`else
              rsp_addr_d  = '0;
              rsp_data_d  = '0;
              rsp_last_d  = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_valid_d = 1'b1;
              state_d     = S_WRSP;
`endif
            end
          endcase
        end
      end
      S_RD: begin
        rsp_data_d  = rf_da;
        rsp_addr_d  = ra_q;
        rsp_last_d  = !dump_q || (ra_q == LAST_IDX);
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (dump_q && !rsp_last_q) begin
            ra_d    = ra_q + AW'(1);
            state_d = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WR: begin
        wen_d       = 1'b0;
        rsp_addr_d  = rd_q;
        rsp_data_d  = din_q;
        rsp_last_d  = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_WRSP;
      end
      S_WRSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef RFM_DBG_FILL_EN
      S_FILL: begin
        // rd_q is the register written on the coming edge; stop after the top one.
        if (rd_q == LAST_IDX) begin
          wen_d       = 1'b0;
          rsp_addr_d  = LAST_IDX;
          rsp_data_d  = din_q;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_WRSP;
        end else begin
          rd_d = rd_q + AW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // The rfm port returns to its reset values whenever the block is idle.
    if (state_d == S_IDLE) begin
      dump_d = 1'b0;
      ra_d   = '0;
      rd_d   = '0;
      din_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      dump_q      <= 1'b0;
      ra_q        <= '0;
      rd_q        <= '0;
      din_q       <= '0;
      wen_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dump_q      <= dump_d;
      ra_q        <= ra_d;
      rd_q        <= rd_d;
      din_q       <= din_d;
      wen_q       <= wen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign dbg_active = (state_q != S_IDLE);
  assign rf_ra      = ra_q;
  assign rf_rd      = rd_q;
  assign rf_din     = din_q;
  assign rf_wen     = wen_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: doc/rfm_dbg.md
# rfm_dbg

Debug-side initiator for the `rfm` register file ports. It accepts single-register read, single-register write, full-file dump and full-file fill commands over a valid/ready command channel and drives the `rfm` read address, write address, write data and write enable accordingly. Results return on a valid/ready response channel. It sits between the debug/monitor link and the register file, and owns the `rfm` port only while `dbg_active` is high; the CPU core is stalled for that time.

## Interface
Parameters:
- `AW`, 4: register address width (16 registers).
- `DW`, 32: register data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on a cycle where it and `cmd_valid` are both high.
- `cmd_op`  in  2  command opcode: 00 read, 01 write, 10 dump, 11 fill.
- `cmd_addr`  in  AW  register address (read and write only).
- `cmd_data`  in  DW  write or fill data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed on a cycle where it and `rsp_valid` are both high.
- `rsp_addr`  out  AW  register index of the response.
- `rsp_data`  out  DW  register value.
- `rsp_last`  out  1  final response of a command.
- `rsp_err`  out  1  command not supported.
- `dbg_active`  out  1  block owns the `rfm` port.
- `rf_ra`  out  AW  to `rfm` `ra`.
- `rf_da`  in  DW  from `rfm` `da`; combinational from `rf_ra`.
- `rf_rd`  out  AW  to `rfm` `rd`.
- `rf_din`  out  DW  to `rfm` `din`.
- `rf_wen`  out  1  write strobe; `rfm` writes on the rising edge where it is high.

## Operation
States: IDLE, RD, RSP, WR, WRSP, FILL.
- **IDLE**
  - `cmd_ready`=1. All other outputs hold their reset values, except that `rsp_*` keep their last values while `rsp_valid`=0.
  - Accept on read: `rf_ra`<=`cmd_addr`, go to RD.
  - Accept on write: `rf_rd`<=`cmd_addr`, `rf_din`<=`cmd_data`, `rf_wen`<=1, go to WR.
  - Accept on dump: `rf_ra`<=0, go to RD, dump flag set.
  - Accept on fill: `rf_rd`<=0, `rf_din`<=`cmd_data`, `rf_wen`<=1, go to FILL.
- **RD**
  - Capture `rsp_data`<=`rf_da` and `rsp_addr`<=`rf_ra`.
  - `rsp_last`<=(not dump) or (`rf_ra`==15). `rsp_valid`<=1. Go to RSP.
- **RSP**
  - Hold all `rsp_*` stable until `rsp_ready`.
  - On handshake: `rsp_valid`<=0.
    - If dump and not last: `rf_ra`<=`rf_ra`+1, go to RD.
    - Otherwise go to IDLE.
- **WR**
  - The write takes effect at the end of this cycle. Next edge: `rf_wen`<=0.
  - Load response: `rsp_addr`=`rf_rd`, `rsp_data`=`rf_din`, `rsp_last`=1. Go to WRSP.
- **WRSP**
  - Same hold and handshake rule as RSP, then go to IDLE.
- **FILL**
  - `rf_wen`=1 each cycle. `rf_rd` increments 0..15, one register per cycle.
  - At `rf_rd`==15: `rf_wen`<=0. Load response: `rsp_addr`=15, `rsp_data`=`cmd_data`, `rsp_last`=1. Go to WRSP.

General rules:
- `dbg_active`=1 in every state except IDLE.
- `cmd_ready`=0 outside IDLE; `cmd_valid` there is ignored, not queued.
- Address arithmetic is modulo 2^AW. The dump terminates on index 15 and never wraps to 0.
- `rsp_err`=0 except as defined under Configuration.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `rf_wen`=0 immediately, `cmd_ready`=1, `rsp_valid`=0, `rsp_last`=0, `rsp_err`=0, `dbg_active`=0, `rf_ra`=0, `rf_rd`=0, `rf_din`=0, `rsp_addr`=0, `rsp_data`=0.
- Reset mid-fill or mid-write aborts the operation. Registers already written stay written; no response is issued.
- Read: `rsp_valid` rises 2 edges after the accept edge when `rsp_ready` is held at 1.
- Write: `rf_wen` is high for exactly 1 cycle, starting the cycle after accept. `rsp_valid` rises 2 edges after accept.
- Dump: 16 responses. With `rsp_ready`=1 throughout, one response every 2 cycles, indices 0..15. Only index 15 has `rsp_last`=1.
- Fill: `rf_wen` is high for exactly 16 consecutive cycles. `rsp_valid` rises 17 edges after accept.
- Back-to-back commands: the next command can be accepted on the cycle after the final response handshake.

## Configuration
- `RFM_DBG_FILL_EN` defined: fill behaves as described above.
- `RFM_DBG_FILL_EN` undefined:
  - Opcode 11 is accepted and goes directly to WRSP; no FILL state is built and no write occurs.
  - Response: `rsp_addr`=0, `rsp_data`=0, `rsp_last`=1, `rsp_err`=1.
  - `rsp_err` returns to 0 on that handshake.

## Test plan
- Write 0xDEADBEEF to r5, then read r5 -> `rf_wen` pulses 1 cycle with `rf_rd`=5. Read response: `rsp_addr`=5, `rsp_data`=0xDEADBEEF, `rsp_last`=1, `rsp_err`=0.
- Preload rN=N*0x11 by writes, dump with `rsp_ready`=1 -> 16 responses, addresses 0..15, data 0x00..0xFF step 0x11, `rsp_last` only on 15, 2-cycle spacing.
- Dump with `rsp_ready` toggling 1 cycle high / 3 cycles low -> no response lost or duplicated; `rsp_*` stable while stalled. `cmd_valid` held high during the dump is not accepted until after the last handshake.
- Fill with 0x12345678, then dump:
  - With `RFM_DBG_FILL_EN`: 16-cycle `rf_wen`, then all 16 dump values equal 0x12345678.
  - Without it: one response with `rsp_err`=1, and register contents unchanged.
- Assert `reset` low during cycle 8 of a fill -> `rf_wen` drops asynchronously, `dbg_active`=0, no response. After release, a dump shows r0..r6 filled and r7..r15 holding their prior values.
